// File: rtl/pc_gen.sv
// Fetch-stage program counter: holds at the reset vector for a programmed number
// of edges, then steps sequentially with trap > redirect > stall priority.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_HOLD | post-reset settle; pc pinned at RESET_VEC, controls ignored
// S_RUN  | live fetch; pc_valid high, pc advances / redirects each edge
module pc_gen #(
   parameter int unsigned XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter int unsigned STEP        = 4,
   parameter int unsigned HOLD_CYCLES = 1,
   parameter int unsigned ALIGN_BITS  = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            trap,
   input  logic [XLEN-1:0] trap_vec,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus,
   output logic            pc_valid,
   output logic            misalign
);

   typedef enum logic [0:0] {
      S_HOLD = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam logic [XLEN-1:0] STEP_W    = XLEN'(STEP);
   localparam logic [3:0]      HOLD_INIT = 4'(HOLD_CYCLES - 1);
   // With ALIGN_BITS = 0 the mask is all ones, so nothing is cleared and misalign stays 0.
   localparam logic [XLEN-1:0] ALIGN_MASK =
      ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            pc_valid_q, pc_valid_d;
   logic            misalign_q, misalign_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_HOLD;
         cnt_q      <= HOLD_INIT;
         pc_q       <= RESET_VEC;
         pc_valid_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pc_q       <= pc_d;
         pc_valid_q <= pc_valid_d;
         misalign_q <= misalign_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pc_d       = pc_q;
      pc_valid_d = pc_valid_q;
      misalign_d = 1'b0;
      unique case (state_q)
         S_HOLD: begin
            if (cnt_q == 4'd0) begin
               state_d    = S_RUN;
               pc_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RUN: begin
            if (trap) begin
               pc_d = trap_vec & ALIGN_MASK;
            end else if (redirect) begin
               pc_d       = redirect_pc & ALIGN_MASK;
               misalign_d = |(redirect_pc & ~ALIGN_MASK);
            end else if (!stall) begin
               pc_d = pc_q + STEP_W;
            end
         end
         default: begin
            state_d = S_HOLD;
         end
      endcase
   end

   assign pc       = pc_q;
   assign pc_plus  = pc_q + STEP_W;
   assign pc_valid = pc_valid_q;
   assign misalign = misalign_q;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the pipelined CPU fetch stage. It holds the PC at a configurable reset vector for a programmable number of cycles after reset, then increments every cycle. It also supports pipeline stall, branch/jump redirect and trap redirect with fixed priority, and flags misaligned redirect targets. It sits in front of instruction memory and takes control inputs from the hazard unit and the execute/exception logic.

## Interface
- XLEN, 32, address width in bits.
- RESET_VEC, 0, PC value loaded on reset; must be ALIGN_BITS-aligned.
- STEP, 4, sequential PC increment in bytes.
- HOLD_CYCLES, 1, clock edges after reset release before the PC may change; legal range 1..15.
- ALIGN_BITS, 2, number of low address bits forced to zero on redirect/trap.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  hold the current PC (hazard unit).
- redirect  in  1  taken branch/jump.
- redirect_pc  in  XLEN  branch/jump target.
- trap  in  1  exception/interrupt entry.
- trap_vec  in  XLEN  trap handler address.
- pc  out  XLEN  registered current fetch address.
- pc_plus  out  XLEN  combinational pc + STEP, truncated to XLEN.
- pc_valid  out  1  registered; high when pc is a live fetch address (RUN state).
- misalign  out  1  registered; one-cycle pulse when an accepted redirect target had nonzero low ALIGN_BITS.

## Operation
- Reset values: pc = RESET_VEC, pc_valid = 0, misalign = 0, state = HOLD, hold counter = HOLD_CYCLES-1.
- HOLD state:
  - pc is held at RESET_VEC and pc_valid = 0.
  - stall, redirect and trap are ignored.
  - The counter decrements each edge. On the edge where the counter is 0, the state moves to RUN and pc_valid becomes 1; pc is unchanged on that edge.
- RUN state, evaluated each edge in priority order:
  1. trap: pc <= trap_vec with low ALIGN_BITS cleared; misalign <= 0.
  2. redirect: pc <= redirect_pc with low ALIGN_BITS cleared; misalign <= OR of redirect_pc's low ALIGN_BITS.
  3. stall: pc unchanged.
  4. Otherwise: pc <= pc + STEP modulo 2^XLEN.
- misalign is 0 on every edge except a redirect edge with a misaligned target.
- Redirect and trap both override stall. A stalled cycle never drops a redirect.
- RUN is left only by reset. There is no halt state.
- Arithmetic: the increment and pc_plus wrap silently at 2^XLEN (for XLEN=32, 32'hFFFF_FFFC + 4 = 0). No carry is exported.
- ALIGN_BITS = 0: no masking is applied, and misalign is constant 0.

## Timing
- Latency from control input to pc: 1 cycle. An input sampled at edge N is visible on pc after edge N.
- With HOLD_CYCLES = H, pc_valid rises after the H-th edge following reset deassertion. The first pc change occurs at edge H+1.
- pc_plus is purely combinational from pc and introduces no added register stage.
- Reset asserted mid-operation: pc, pc_valid and misalign take their reset values immediately, without waiting for a clock edge. The full HOLD sequence restarts after release.
- Reset deassertion is assumed synchronous to clk. A control input asserted in the same cycle reset releases is ignored, because the block is in HOLD.
- trap, redirect and stall all asserted in the same cycle: trap wins, and misalign is 0.

## Test plan
- Reset, HOLD_CYCLES=1, RESET_VEC=0, no control: pc reads 0, 0, 4, 8 on successive edges; pc_valid goes 0 -> 1 after edge 1.
- HOLD_CYCLES=3, redirect=1 with redirect_pc=0x100 during HOLD: the redirect is ignored; pc_valid rises after edge 3; pc = 4 after edge 4.
- RUN at pc=0x20: stall for 2 cycles -> pc stays 0x20. Then stall=1 together with redirect=1 to 0x80 -> pc = 0x80 and misalign = 0.
- Redirect to 0x103 -> pc = 0x100 and misalign = 1 for exactly one cycle. Then trap=1, redirect=1, trap_vec=0x200 together -> pc = 0x200 and misalign = 0.
- Wrap: redirect to 0xFFFF_FFFC, then no control -> pc = 0x0000_0000; pc_plus reads 0x0000_0000 while pc = 0xFFFF_FFFC.
- Assert rst asynchronously between edges while pc=0x40 -> pc = RESET_VEC and pc_valid = 0 before the next edge; the HOLD sequence repeats after release.
